// File: rtl/vld_data_collector.sv
// Vector load data collector: issues one bus read per address-unit beat and
// compacts the enabled bytes of each response into element writes.
module vld_data_collector (
    input  logic        clk_i,
    input  logic        n_rst_i,
    input  logic        start_i,
    input  logic [4:0]  vl_i,
    input  logic [1:0]  vsew_i,
    input  logic [31:0] au_addr_i,
    input  logic [3:0]  au_be_i,
    input  logic        au_valid_i,
    output logic        au_next_o,
    output logic        data_req_o,
    output logic [31:0] data_addr_o,
    output logic [3:0]  data_be_o,
    output logic        data_we_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    output logic        wr_valid_o,
    output logic [31:0] wr_data_o,
    output logic [2:0]  wr_count_o,
    output logic [4:0]  wr_idx_o,
    output logic        done_o,
    output logic        busy_o,
    output logic        proto_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_AU = 2'd1,
        ST_REQ     = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    function automatic logic [31:0] compact_bytes(input logic [3:0] be, input logic [31:0] data);
        logic [31:0] res;
        logic [1:0]  pos;
        res = 32'd0;
        pos = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[{pos, 3'b000} +: 8] = data[i*8 +: 8];
                pos = pos + 2'd1;
            end else begin
                pos = pos;
            end
        end
        compact_bytes = res;
    endfunction

    state_e      state_q, state_d;
    logic [4:0]  vl_q, vl_d;
    logic [1:0]  vsew_q, vsew_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic        proto_err_q, proto_err_d;
    logic        wr_valid_q, wr_valid_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [2:0]  wr_count_q, wr_count_d;
    logic [4:0]  wr_idx_q, wr_idx_d;
    logic        done_q, done_d;
    logic        au_next_q, au_next_d;
    logic        req_q, req_d;
    logic        busy_q, busy_d;

    logic [2:0]  raw_s;
    logic [5:0]  remain_s;
    logic [2:0]  take_s;
    logic [5:0]  cnt_upd_s;
    logic [31:0] packed_s;

    // Element accounting for the response on the bus; the take never overruns vl.
    always_comb begin
        raw_s    = popcount4(be_q) >> vsew_q;
        remain_s = {1'b0, vl_q} - cnt_q;
        if ({3'b000, raw_s} < remain_s) begin
            take_s = raw_s;
        end else begin
            take_s = remain_s[2:0];
        end
        cnt_upd_s = cnt_q + {3'b000, take_s};
        packed_s  = compact_bytes(be_q, data_rdata_i);
    end

    // Next-state and registered-output computation; start_i overrides everything.
    always_comb begin
        state_d     = state_q;
        vl_d        = vl_q;
        vsew_d      = vsew_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        be_d        = be_q;
        proto_err_d = proto_err_q;
        wr_valid_d  = 1'b0;
        wr_data_d   = 32'd0;
        wr_count_d  = 3'd0;
        wr_idx_d    = 5'd0;
        done_d      = 1'b0;
        au_next_d   = 1'b0;
        if (start_i) begin
            vl_d   = vl_i;
            vsew_d = vsew_i;
            cnt_d  = 6'd0;
            if (vsew_i == 2'b11) begin
                proto_err_d = 1'b1;
                state_d     = ST_IDLE;
            end else if (vl_i == 5'd0) begin
                proto_err_d = 1'b0;
                done_d      = 1'b1;
                state_d     = ST_IDLE;
            end else begin
                proto_err_d = 1'b0;
                state_d     = ST_WAIT_AU;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (au_valid_i) begin
                        proto_err_d = 1'b1;
                    end else begin
                        proto_err_d = proto_err_q;
                    end
                end
                ST_WAIT_AU: begin
                    if (au_valid_i) begin
                        addr_d  = au_addr_i;
                        be_d    = au_be_i;
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_WAIT_AU;
                    end
                end
                ST_REQ: begin
                    if (au_valid_i) begin
                        proto_err_d = 1'b1;
                    end else begin
                        proto_err_d = proto_err_q;
                    end
                    if (data_gnt_i) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
                ST_RESP: begin
                    if (au_valid_i) begin
                        proto_err_d = 1'b1;
                    end else begin
                        proto_err_d = proto_err_q;
                    end
                    if (data_rvalid_i) begin
                        wr_valid_d = 1'b1;
                        wr_data_d  = packed_s;
                        wr_count_d = take_s;
                        wr_idx_d   = cnt_q[4:0];
                        cnt_d      = cnt_upd_s;
                        if (cnt_upd_s == {1'b0, vl_q}) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            au_next_d = 1'b1;
                            state_d   = ST_WAIT_AU;
                        end
                    end else begin
                        state_d = ST_RESP;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        req_d  = (state_d == ST_REQ);
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset drops any outstanding bus request at once.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q     <= ST_IDLE;
            vl_q        <= 5'd0;
            vsew_q      <= 2'd0;
            cnt_q       <= 6'd0;
            addr_q      <= 32'd0;
            be_q        <= 4'd0;
            proto_err_q <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_data_q   <= 32'd0;
            wr_count_q  <= 3'd0;
            wr_idx_q    <= 5'd0;
            done_q      <= 1'b0;
            au_next_q   <= 1'b0;
            req_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vl_q        <= vl_d;
            vsew_q      <= vsew_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            proto_err_q <= proto_err_d;
            wr_valid_q  <= wr_valid_d;
            wr_data_q   <= wr_data_d;
            wr_count_q  <= wr_count_d;
            wr_idx_q    <= wr_idx_d;
            done_q      <= done_d;
            au_next_q   <= au_next_d;
            req_q       <= req_d;
            busy_q      <= busy_d;
        end
    end

    assign au_next_o   = au_next_q;
    assign data_req_o  = req_q;
    assign data_addr_o = addr_q;
    assign data_be_o   = be_q;
    assign data_we_o   = 1'b0;
    assign wr_valid_o  = wr_valid_q;
    assign wr_data_o   = wr_data_q;
    assign wr_count_o  = wr_count_q;
    assign wr_idx_o    = wr_idx_q;
    assign done_o      = done_q;
    assign busy_o      = busy_q;
    assign proto_err_o = proto_err_q;

endmodule
